// File: rtl/cordic_pkg.sv
// Shared constants and types for the iterative rotation-mode CORDIC engine.
// Angles use the full word as one turn: 2^WIDTH corresponds to 360 degrees.
package cordic_pkg;

  localparam int WIDTH  = 32;
  localparam int ITER   = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    ITERATE  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ANG_90    = 32'h4000_0000;
  localparam logic [WIDTH-1:0] ANG_45    = 32'h2000_0000;
  // 1/K in Q2.30: callers pre-scale x/y by this to cancel the CORDIC gain.
  localparam logic [WIDTH-1:0] K_INV_Q30 = 32'h26DD_3B6A;

endpackage : cordic_pkg

// File: rtl/cordic_atan_rom.sv
// Arctangent table: entry i holds round(atan(2^-i) * 2^32 / 360).
// Synchronous read: data reflects the address sampled at the previous edge.
module cordic_atan_rom #(
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 32
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  logic [WIDTH-1:0] table_word;

  always_comb begin
    table_word = '0;
    case (addr)
      4'd0:  table_word = 32'h2000_0000;
      4'd1:  table_word = 32'h12E4_051E;
      4'd2:  table_word = 32'h09FB_385B;
      4'd3:  table_word = 32'h0511_11D4;
      4'd4:  table_word = 32'h028B_0D43;
      4'd5:  table_word = 32'h0145_D7E1;
      4'd6:  table_word = 32'h00A2_F61E;
      4'd7:  table_word = 32'h0051_7C55;
      4'd8:  table_word = 32'h0028_BE53;
      4'd9:  table_word = 32'h0014_5F2F;
      4'd10: table_word = 32'h000A_2F98;
      4'd11: table_word = 32'h0005_17CC;
      4'd12: table_word = 32'h0002_8BE6;
      4'd13: table_word = 32'h0001_45F3;
      4'd14: table_word = 32'h0000_A2FA;
      4'd15: table_word = 32'h0000_517D;
      default: table_word = '0;
    endcase
  end

  // NOTE: the read register has no reset; like a memory macro its contents
  // are don't-care until the first address is sampled.
  always_ff @(posedge clk) begin
    data <= table_word;
  end

endmodule : cordic_atan_rom

// File: rtl/cordic_stage_alu.sv
// One combinational CORDIC micro-rotation; the sequencer reuses it every
// iteration with the current shift amount and table angle.
module cordic_stage_alu #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
) (
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  input  logic [WIDTH-1:0]  z,
  input  logic [WIDTH-1:0]  atan,
  input  logic [ADDR_W-1:0] shift,
  output logic [WIDTH-1:0]  x_next,
  output logic [WIDTH-1:0]  y_next,
  output logic [WIDTH-1:0]  z_next
);

  logic             neg;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;

  // A negative residual angle rotates clockwise (d = -1).
  assign neg  = z[WIDTH-1];
  assign x_sh = WIDTH'($signed(x) >>> shift);
  assign y_sh = WIDTH'($signed(y) >>> shift);

  // All sums wrap modulo 2^WIDTH by construction of the unsigned vectors.
  always_comb begin
    x_next = neg ? (x + y_sh) : (x - y_sh);
    y_next = neg ? (y - x_sh) : (y + x_sh);
    z_next = neg ? (z + atan) : (z - atan);
  end

endmodule : cordic_stage_alu

// File: rtl/cordic_rot_seq.sv
// Iterative rotation-mode CORDIC sequencer: walks the atan ROM 0..ITER-1,
// rotates (x,y) by z one micro-step per cycle and reports with a done pulse.
module cordic_rot_seq #(
  parameter int WIDTH  = 32,
  parameter int ITER   = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  x_in,
  input  logic [WIDTH-1:0]  y_in,
  input  logic [WIDTH-1:0]  z_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WIDTH-1:0]  rom_data,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  x_out,
  output logic [WIDTH-1:0]  y_out,
  output logic [WIDTH-1:0]  z_out
);

  import cordic_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ITER = ADDR_W'(ITER - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]  x_r;
  logic [WIDTH-1:0]  y_r;
  logic [WIDTH-1:0]  z_r;
  logic [ADDR_W-1:0] iter;

  logic [WIDTH-1:0]  x_nx;
  logic [WIDTH-1:0]  y_nx;
  logic [WIDTH-1:0]  z_nx;
  logic [ADDR_W:0]   addr_ahead;
  logic [ADDR_W-1:0] addr_sat;
  logic              last_iter;

  cordic_stage_alu #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_stage (
    .x      (x_r),
    .y      (y_r),
    .z      (z_r),
    .atan   (rom_data),
    .shift  (iter),
    .x_next (x_nx),
    .y_next (y_nx),
    .z_next (z_nx)
  );

  // The ROM runs two entries ahead of the datapath; clamp at the last entry.
  assign addr_ahead = {1'b0, iter} + (ADDR_W+1)'(2);
  assign addr_sat   = (addr_ahead > {1'b0, LAST_ITER}) ? LAST_ITER
                                                       : addr_ahead[ADDR_W-1:0];
  assign last_iter  = (iter == LAST_ITER);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, matching the hardware regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = PREFETCH;
      PREFETCH: state_nxt = ITERATE;
      ITERATE:  if (last_iter) state_nxt = DONE;
      DONE:     state_nxt = start ? PREFETCH : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      iter     <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      z_out    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done     <= 1'b0;
          rom_addr <= '0;
          if (start) begin
            x_r  <= x_in;
            y_r  <= y_in;
            z_r  <= z_in;
            iter <= '0;
            busy <= 1'b1;
          end
        end
        PREFETCH: begin
          rom_addr <= ADDR_W'(1);
        end
        ITERATE: begin
          x_r      <= x_nx;
          y_r      <= y_nx;
          z_r      <= z_nx;
          iter     <= iter + ADDR_W'(1);
          rom_addr <= addr_sat;
          if (last_iter) begin
            x_out <= x_nx;
            y_out <= y_nx;
            z_out <= z_nx;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        default: begin
          busy <= 1'b0;
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule : cordic_rot_seq

// File: tb/tb_cordic_rot_seq.sv
// Directed bench for cordic_rot_seq with the atan ROM attached; expected
// results are hand-computed rotations of a gain-compensated unit vector.
module tb_cordic_rot_seq;

  import cordic_pkg::*;

  localparam int unsigned TOL = 32'h0001_0000;
  localparam logic [31:0] ONE_Q30  = 32'h4000_0000;
  localparam logic [31:0] COS45    = 32'h2D41_3CCD;
  localparam logic [31:0] NEG_SIN45 = 32'hD2BE_C333;
  localparam logic [31:0] NEG_45   = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] x_in = '0;
  logic [31:0] y_in = '0;
  logic [31:0] z_in = '0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data;
  logic        busy;
  logic        done;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [31:0] z_out;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_rot_seq #(.WIDTH(32), .ITER(16), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out)
  );

  cordic_atan_rom #(.ADDR_W(4), .WIDTH(32)) u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (rom_data)
  );

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp, input int unsigned tol);
    logic [31:0] diff;
    longint      mag;
    diff = act - exp;
    mag  = longint'($signed(diff));
    if (mag < 0) mag = -mag;
    n_vec++;
    if (mag > longint'(tol)) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (tol %0d)", tag, act, exp, tol);
    end
  endtask

  task automatic start_op(input logic [31:0] xv, input logic [31:0] yv,
                          input logic [31:0] zv);
    @(negedge clk);
    x_in  = xv;
    y_in  = yv;
    z_in  = zv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      #1;
    end while (!done && edges < 40);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    int n2;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0, 0);
    check("rst_done", 32'(done), 32'd0, 0);
    check("rst_addr", 32'(rom_addr), 32'd0, 0);
    check("rst_x", x_out, 32'd0, 0);
    check("rst_y", y_out, 32'd0, 0);
    check("rst_z", z_out, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0 deg: latency and gain-compensated unit vector
    start_op(K_INV_Q30, 32'd0, 32'd0);
    check("a_busy", 32'(busy), 32'd1, 0);
    wait_done(n);
    check("a_lat", 32'(n), 32'd17, 0);
    check("a_x", x_out, ONE_Q30, TOL);
    check("a_y", y_out, 32'd0, TOL);
    check("a_z", z_out, 32'd0, TOL);
    check("a_busy_done", 32'(busy), 32'd0, 0);
    @(posedge clk);
    #1;
    check("a_done_fall", 32'(done), 32'd0, 0);

    // +45 deg with ROM address sequence
    start_op(K_INV_Q30, 32'd0, ANG_45);
    check("b_addr0", 32'(rom_addr), 32'd0, 0);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("b_addr%0d", k), 32'(rom_addr), 32'(k), 0);
    end
    wait_done(n);
    check("b_lat", 32'(15 + n), 32'd17, 0);
    check("b_x", x_out, COS45, TOL);
    check("b_y", y_out, COS45, TOL);
    check("b_z", z_out, 32'd0, TOL);

    // -45 deg
    start_op(K_INV_Q30, 32'd0, NEG_45);
    wait_done(n);
    check("c_lat", 32'(n), 32'd17, 0);
    check("c_x", x_out, COS45, TOL);
    check("c_y", y_out, NEG_SIN45, TOL);

    // start pulsed at iteration 5 is ignored
    start_op(K_INV_Q30, 32'd0, 32'd0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    x_in  = 32'h1111_1111;
    y_in  = 32'h2222_2222;
    z_in  = ANG_45;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("d_busy", 32'(busy), 32'd1, 0);
    wait_done(n);
    check("d_lat", 32'(7 + n), 32'd17, 0);
    check("d_x", x_out, ONE_Q30, TOL);
    check("d_y", y_out, 32'd0, TOL);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= done;
    end
    check("d_one_pulse", 32'(seen), 32'd0, 0);
    check("d_idle_busy", 32'(busy), 32'd0, 0);

    // Reset at iteration 8 abandons the rotation
    start_op(K_INV_Q30, 32'd0, ANG_45);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("e_busy", 32'(busy), 32'd0, 0);
    check("e_done", 32'(done), 32'd0, 0);
    check("e_addr", 32'(rom_addr), 32'd0, 0);
    check("e_x", x_out, 32'd0, 0);
    check("e_y", y_out, 32'd0, 0);
    check("e_z", z_out, 32'd0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen |= done;
    end
    check("e_no_done", 32'(seen), 32'd0, 0);
    start_op(K_INV_Q30, 32'd0, ANG_45);
    wait_done(n);
    check("e_lat", 32'(n), 32'd17, 0);
    check("e_x2", x_out, COS45, TOL);
    check("e_y2", y_out, COS45, TOL);

    // start held across done: back-to-back operations
    @(negedge clk);
    x_in  = K_INV_Q30;
    y_in  = 32'd0;
    z_in  = 32'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(n);
    check("f_lat1", 32'(n), 32'd17, 0);
    check("f_x1", x_out, ONE_Q30, TOL);
    @(negedge clk);
    z_in = NEG_45;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("f_rebusy", 32'(busy), 32'd1, 0);
    check("f_done_fall", 32'(done), 32'd0, 0);
    check("f_x_held", x_out, ONE_Q30, TOL);
    wait_done(n2);
    check("f_lat2", 32'(n2), 32'd17, 0);
    check("f_x2", x_out, COS45, TOL);
    check("f_y2", y_out, NEG_SIN45, TOL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cordic_rot_seq
